mux_sum_sequencer: RTL and testbench
====================================

// Module: mux_sum_sequencer
// PURPOSE
// Operand sequencer/accumulator wrapped around the 4:1 operand mux of the 4-bit adder datapath.
// - Accepts a 4-operand packet (a,b,c,d) via valid/ready and registers it onto the mux inputs.
// - Steps the mux select 0..3, accumulates the returned mux output, and presents the sum via valid/ready.
// - Sits directly upstream (drives op_*, sel) and downstream (consumes mux_y) of the mux.
// PARAMETERS
// WIDTH  4        operand / mux data width
// ACC_W  WIDTH+2  accumulator and sum width; holds 4*(2^WIDTH-1) without loss
// PORTS
// clk        in   1      single clock, all state updates on rising edge
// rst_n      in   1      synchronous, active-low reset
// in_valid   in   1      operand packet valid
// in_ready   out  1      block can accept a packet; high only in IDLE
// in_a..in_d in   WIDTH  operand packet, captured on in_valid && in_ready
// op_a..op_d out  WIDTH  registered operands; drive mux inputs a..d
// sel        out  2      registered mux select
// mux_y      in   WIDTH  mux output y (combinational from op_*, sel)
// out_valid  out  1      sum valid; high only in DONE
// out_ready  in   1      consumer accepts sum
// sum        out  ACC_W  accumulated result, stable while out_valid
// busy       out  1      high in ACCUM or DONE
// BEHAVIOUR
// - Reset (rst_n low at an edge): state=IDLE; op_a..op_d=0, sel=0, acc=0, sum=0, out_valid=0, busy=0; in_ready=1 after reset.
// - Reset mid-operation behaves identically: the packet in flight is discarded, with no partial output.
// - FSM states: IDLE, ACCUM, DONE.
//   IDLE:  in_ready=1. On in_valid && in_ready: op_* <= in_*, sel <= 0, acc <= 0, -> ACCUM.
//   ACCUM: each edge acc <= acc + {zero-ext mux_y}; if sel==3 -> DONE, else sel <= sel+1.
//   DONE:  out_valid=1, sum=acc. On out_ready -> IDLE, sel <= 0. Without out_ready, hold all outputs.
// - Latency: packet accepted at edge E0; mux_y is sampled at E1..E4 for sel=0,1,2,3; out_valid is high from E4.
// - Throughput: at most one packet per 6 cycles. in_ready is low in DONE, so no accept occurs on the same edge as the output handshake.
// - in_valid outside IDLE is ignored. in_* may change freely when not captured.
// - Arithmetic is unsigned. The accumulator cannot wrap at ACC_W; no carry out of acc.
// - sel and op_* are registered, so there is no combinational loop through the external mux.
// - mux_y is don't-care outside ACCUM.
// - sum is registered and equals acc. It is held after the handshake until the next result overwrites it.
// CONFIGURATION
// MUX_SUM_OVF_EN
//   Defined: adds output port ovf (1 bit), reset 0.
//     In DONE, ovf = (acc[ACC_W-1:WIDTH] != 0), i.e. the sum does not fit in WIDTH bits.
//     ovf is 0 in IDLE/ACCUM.
//   Undefined: no ovf port and no extra logic; all other behaviour is identical.
// TESTING
// 1. in a/b/c/d=1,2,3,4 -> sel 0,1,2,3 on the 4 cycles after accept; out_valid after E4; sum=10 (0x0A); ovf=0.
// 2. all operands 0xF -> sum=60 (0x3C); with MUX_SUM_OVF_EN, ovf=1 in DONE.
// 3. out_ready low 3 cycles in DONE with in_valid held high -> out_valid, sum, ovf stable; in_ready=0; no capture; sum=0x0A.
//    Then out_ready=1 -> IDLE next cycle.
// 4. rst_n low during ACCUM with sel=1 -> next cycle IDLE, sel=0, sum=0, out_valid=0, in_ready=1.
//    Then new packet 5,5,5,5 -> sum=20.
// 5. in_valid, out_ready tied high; packets (1,1,1,1) then (2,3,4,5) -> accepts 6 cycles apart; sums 4 then 14.
// 6. all operands 0 -> sum=0, ovf=0; busy high exactly 5 cycles with out_ready tied high.

Source files
------------

// File: rtl/mux_sum_sequencer_if.sv
// Packet-in / sum-out handshake bundle for mux_sum_sequencer.
// The master drives the operand packet and consumes the sum; the slave is the sequencer.
interface mux_sum_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = WIDTH + 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_d;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, out_ready,
    output in_ready, out_valid, sum
  );
endinterface

// File: rtl/mux_sum_sequencer.sv
// Operand sequencer/accumulator around the external 4:1 operand mux.
// Captures a 4-operand packet, steps sel 0..3 over the registered operands,
// accumulates the returned mux_y and presents the sum on a valid/ready port.
// Optional build macro MUX_SUM_OVF_EN adds the ovf output (sum exceeds WIDTH bits).
//
// state | meaning
// IDLE  | waiting for an operand packet, in_ready high
// ACCUM | sel steps 0..3, mux_y added into acc each cycle
// DONE  | sum presented with out_valid, waiting for out_ready
module mux_sum_sequencer #(
  parameter int WIDTH = 4,
  parameter int ACC_W = WIDTH + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_sum_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic [WIDTH-1:0]     op_c,
  output logic [WIDTH-1:0]     op_d,
  output logic [1:0]           sel,
  input  logic [WIDTH-1:0]     mux_y,
`ifdef MUX_SUM_OVF_EN
  output logic                 ovf,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] sum_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Next accumulator value: zero-extended mux output added to the running sum.
  assign acc_next = acc + {{(ACC_W-WIDTH){1'b0}}, mux_y};

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;

  // Sequencer FSM; every output is registered so the external mux sees no loop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op_c        <= '0;
      op_d        <= '0;
      sel         <= 2'd0;
      acc         <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
`ifdef MUX_SUM_OVF_EN
      ovf         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            op_a       <= bus.in_a;
            op_b       <= bus.in_b;
            op_c       <= bus.in_c;
            op_d       <= bus.in_d;
            sel        <= 2'd0;
            acc        <= '0;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          if (sel == 2'd3) begin
            // Last operand: publish the result on the same edge it completes.
            sum_q       <= acc_next;
            out_valid_q <= 1'b1;
`ifdef MUX_SUM_OVF_EN
            ovf         <= |acc_next[ACC_W-1:WIDTH];
`endif
            state       <= DONE;
          end else begin
            sel <= sel + 2'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
            sel         <= 2'd0;
`ifdef MUX_SUM_OVF_EN
            ovf         <= 1'b0;
`endif
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy        <= 1'b0;
          sel         <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sum_sequencer.sv
// Directed bench for mux_sum_sequencer with a behavioural model of the external 4:1 mux.
module tb_mux_sum_sequencer;
  localparam int WIDTH = 4;
  localparam int ACC_W = WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] op_a, op_b, op_c, op_d;
  logic [1:0]       sel;
  logic [WIDTH-1:0] mux_y;
  logic             busy;
  logic             ovf_obs;
`ifdef MUX_SUM_OVF_EN
  logic             ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  mux_sum_sequencer_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

  mux_sum_sequencer #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .op_a  (op_a),
    .op_b  (op_b),
    .op_c  (op_c),
    .op_d  (op_d),
    .sel   (sel),
    .mux_y (mux_y),
`ifdef MUX_SUM_OVF_EN
    .ovf   (ovf),
`endif
    .busy  (busy)
  );

  // External operand mux model
  always_comb begin
    case (sel)
      2'd0:    mux_y = op_a;
      2'd1:    mux_y = op_b;
      2'd2:    mux_y = op_c;
      default: mux_y = op_d;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one packet, check 4-cycle latency, sum and ovf, then complete the handshake.
  task automatic run_packet(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input int exp_sum, input logic exp_ovf);
    int lat;
    bit seen;
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("pkt_accept_busy", 32'(busy), 32'd1);
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      lat++;
      if (bus.out_valid) seen = 1'b1;
    end
    check("pkt_seen", 32'(seen), 32'd1);
    check("pkt_latency", 32'(lat), 32'd4);
    check("pkt_sum", 32'(bus.sum), 32'(exp_sum));
`ifdef MUX_SUM_OVF_EN
    check("pkt_ovf", 32'(ovf_obs), 32'(exp_ovf));
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("pkt_release_ovalid", 32'(bus.out_valid), 32'd0);
    check("pkt_release_iready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin : main
    int t_acc[2];
    int sums[2];
    int n_acc, n_sum, busy_cnt, zsum;
    bit prev_busy, zseen;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_ovf", 32'(ovf_obs), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1 + 3: packet 1,2,3,4 with sel stepping, then stall in DONE with in_valid high
    bus.in_a = 4'd1; bus.in_b = 4'd2; bus.in_c = 4'd3; bus.in_d = 4'd4;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t1_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("t1_sel0", 32'(sel), 32'd0);
    check("t1_op_a", 32'(op_a), 32'd1);
    check("t1_op_d", 32'(op_d), 32'd4);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("t1_sel_step", 32'(sel), 32'(k));
      check("t1_no_ovalid", 32'(bus.out_valid), 32'd0);
    end
    tick();
    check("t1_ovalid", 32'(bus.out_valid), 32'd1);
    check("t1_sum", 32'(bus.sum), 32'h0A);
    check("t1_ovf", 32'(ovf_obs), 32'd0);
    bus.in_a = 4'd9; bus.in_b = 4'd9; bus.in_c = 4'd9; bus.in_d = 4'd9;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_hold_ovalid", 32'(bus.out_valid), 32'd1);
      check("t3_hold_sum", 32'(bus.sum), 32'h0A);
      check("t3_hold_ovf", 32'(ovf_obs), 32'd0);
      check("t3_hold_iready", 32'(bus.in_ready), 32'd0);
      check("t3_no_capture", 32'(op_a), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("t3_idle_ovalid", 32'(bus.out_valid), 32'd0);
    check("t3_idle_iready", 32'(bus.in_ready), 32'd1);
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_idle_sel", 32'(sel), 32'd0);
    check("t3_sum_held", 32'(bus.sum), 32'h0A);
    tick();
    check("t3_no_late_capture", 32'(op_a), 32'd1);

    // 2: all 0xF -> 60, overflow
    run_packet(4'hF, 4'hF, 4'hF, 4'hF, 60, 1'b1);

    // 4: reset mid-ACCUM at sel=1, then 5,5,5,5
    bus.in_a = 4'd7; bus.in_b = 4'd7; bus.in_c = 4'd7; bus.in_d = 4'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("t4_sel1", 32'(sel), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t4_rst_iready", 32'(bus.in_ready), 32'd1);
    check("t4_rst_sel", 32'(sel), 32'd0);
    check("t4_rst_sum", 32'(bus.sum), 32'd0);
    check("t4_rst_ovalid", 32'(bus.out_valid), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t4_no_partial", 32'(bus.out_valid), 32'd0);
    end
    run_packet(4'd5, 4'd5, 4'd5, 4'd5, 20, 1'b1);

    // 5: back-to-back with in_valid and out_ready tied high
    bus.in_a = 4'd1; bus.in_b = 4'd1; bus.in_c = 4'd1; bus.in_d = 4'd1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    n_acc = 0;
    n_sum = 0;
    prev_busy = busy;
    t_acc[0] = 0; t_acc[1] = 0; sums[0] = 0; sums[1] = 0;
    for (int cyc = 1; cyc <= 24 && n_sum < 2; cyc++) begin
      tick();
      if (busy && !prev_busy && n_acc < 2) begin
        t_acc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          bus.in_a = 4'd2; bus.in_b = 4'd3; bus.in_c = 4'd4; bus.in_d = 4'd5;
        end
      end
      if (bus.out_valid && n_sum < 2) begin
        sums[n_sum] = int'(bus.sum);
        n_sum++;
      end
      prev_busy = busy;
    end
    bus.in_valid = 1'b0;
    check("t5_n_sums", 32'(n_sum), 32'd2);
    check("t5_n_accepts", 32'(n_acc), 32'd2);
    check("t5_spacing", 32'(t_acc[1] - t_acc[0]), 32'd6);
    check("t5_sum0", 32'(sums[0]), 32'd4);
    check("t5_sum1", 32'(sums[1]), 32'd14);
    tick();
    check("t5_idle", 32'(bus.in_ready), 32'd1);

    // 6: zeros, busy exactly 5 cycles
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    busy_cnt = busy ? 1 : 0;
    zseen = 1'b0;
    zsum = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy) busy_cnt++;
      if (bus.out_valid) begin
        zseen = 1'b1;
        zsum = int'(bus.sum);
        check("t6_ovf", 32'(ovf_obs), 32'd0);
      end
    end
    check("t6_seen", 32'(zseen), 32'd1);
    check("t6_sum", 32'(zsum), 32'd0);
    check("t6_busy_cycles", 32'(busy_cnt), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
